// File: rtl/ddr3_pix_gearbox.sv
// ---------------------------------------------------------------------------
// ddr3_pix_gearbox
//
// Purpose:
//   This stage sits downstream of ddr3_usr_logic in the ddr3_emif_clk domain.
//   It stores the 256-bit words returned by DDR3 in a small word FIFO and
//   throttles ddr3_usr_logic through read_req_out. It then unpacks the byte
//   stream into 24-bit pixels. Pixels leave on a valid/ready handshake with
//   SOF/EOF framing.
//
//   Byte k of a word is data[8k+7:8k]. The stream runs word0 byte0..31, then
//   word1 byte0 and onward. A pixel is {b[n+2], b[n+1], b[n]}, so the first
//   byte of the stream lands in [7:0].
//
// Parameters:
//   FIFO_DEPTH  word FIFO depth (power of 2, >= 4)
//   SKID        words upstream may still return after read_req_out falls
//
// Ports:
//   ddr3_emif_clk       in   clock
//   ddr3_emif_rst_n     in   asynchronous active-low reset
//   frame_start_in      in   start a frame; latches frame_pix_num_in (IDLE only)
//   frame_pix_num_in    in   [31:0] pixels in the frame
//   frame_done_out      out  1-cycle pulse in the flush cycle after EOF
//   read_req_out        out  request more words from ddr3_usr_logic
//   data_ready_in       in   upstream status (informational only)
//   read_data_in        in   [287:0]: [255:0] data, [287:256] sideband (ignored)
//   read_data_valid_in  in   word strobe
//   pix_data_out        out  [23:0] pixel
//   pix_valid_out       out  pixel valid
//   pix_ready_in        in   pixel accept
//   pix_sof_out         out  first pixel of frame
//   pix_eof_out         out  last pixel of frame
//   fifo_overflow_out   out  sticky: a word arrived while the FIFO was full
//   pix_err_out         out  sticky error flag (see PIX_ERR_CHECK_EN below)
//
// Optional feature (macro PIX_ERR_CHECK_EN):
//   When defined, pix_err_out sets in two cases:
//     - RUN starves: FIFO empty and buffer < 3 bytes for more than 64
//       consecutive cycles.
//     - A word arrives while in IDLE.
//   When undefined, pix_err_out is tied to 0 and the checker is not built.
// ---------------------------------------------------------------------------
module ddr3_pix_gearbox #(
    parameter int FIFO_DEPTH = 8,
    parameter int SKID       = 4
) (
    input  logic          ddr3_emif_clk,
    input  logic          ddr3_emif_rst_n,
    input  logic          frame_start_in,
    input  logic [31:0]   frame_pix_num_in,
    output logic          frame_done_out,
    output logic          read_req_out,
    input  logic          data_ready_in,
    input  logic [287:0]  read_data_in,
    input  logic          read_data_valid_in,
    output logic [23:0]   pix_data_out,
    output logic          pix_valid_out,
    input  logic          pix_ready_in,
    output logic          pix_sof_out,
    output logic          pix_eof_out,
    output logic          fifo_overflow_out,
    output logic          pix_err_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [31:0]    pix_num_reg, pix_num_next;
    logic [31:0]    pix_cnt_reg, pix_cnt_next;

    // Word FIFO
    logic [255:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  fifo_wr_ptr_reg, fifo_rd_ptr_reg;
    logic [CW-1:0]  fifo_cnt_reg, fifo_cnt_next;
    logic           fifo_full, fifo_empty, fifo_wr, fifo_pop;
    logic [255:0]   fifo_rd_data;

    // Byte buffer. It holds at most 2 residual bytes plus one 32-byte word,
    // so 34 bytes in total. Bits above buf_cnt are always kept at zero, so a
    // newly popped word can be OR-ed in directly above the residual bytes.
    logic [271:0]   buf_reg, buf_next, buf_shifted;
    logic [5:0]     buf_cnt_reg, buf_cnt_next, rem_cnt;

    logic           xfer;
    logic           pix_valid_next;
    logic           pix_valid_reg, pix_sof_reg, pix_eof_reg, done_reg;
    logic           read_req_reg, ovf_reg;
    logic [23:0]    pix_data_reg;

    // Upstream status and sideband carry no meaning for this stage.
    logic           unused_sigs;
    assign unused_sigs = ^{data_ready_in, read_data_in[287:256]};

    assign fifo_full    = (fifo_cnt_reg == CW'(FIFO_DEPTH));
    assign fifo_empty   = (fifo_cnt_reg == '0);
    assign fifo_wr      = read_data_valid_in && !fifo_full;
    assign fifo_rd_data = fifo_mem[fifo_rd_ptr_reg];
    assign fifo_cnt_next = fifo_cnt_reg + {{(CW-1){1'b0}}, fifo_wr}
                                        - {{(CW-1){1'b0}}, fifo_pop};

    // Storage array has no reset; contents only matter when the count says so.
    always_ff @(posedge ddr3_emif_clk) begin
        if (fifo_wr) begin
            fifo_mem[fifo_wr_ptr_reg] <= read_data_in[255:0];
        end
    end

    always_comb begin
        state_next   = state_reg;
        pix_num_next = pix_num_reg;
        pix_cnt_next = pix_cnt_reg;

        xfer        = pix_valid_reg && pix_ready_in;
        buf_shifted = xfer ? (buf_reg >> 24) : buf_reg;
        rem_cnt     = xfer ? (buf_cnt_reg - 6'd3) : buf_cnt_reg;

        // Refill as soon as the residual cannot form a whole pixel. A pop can
        // happen in the same cycle as a consume, which sustains 1 pixel/cycle.
        fifo_pop     = (state_reg == ST_RUN) && (rem_cnt < 6'd3) && !fifo_empty;
        buf_next     = buf_shifted;
        buf_cnt_next = rem_cnt;
        if (fifo_pop) begin
            buf_next     = buf_shifted | ({16'b0, fifo_rd_data} << {rem_cnt, 3'b000});
            buf_cnt_next = rem_cnt + 6'd32;
        end

        if (xfer) begin
            pix_cnt_next = pix_cnt_reg + 32'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (frame_start_in) begin
                    pix_num_next = frame_pix_num_in;
                    pix_cnt_next = '0;
                    state_next   = (frame_pix_num_in == '0) ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer && (pix_cnt_reg == pix_num_reg - 32'd1)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Drop leftover bytes so the next frame starts on a word boundary.
                buf_next     = '0;
                buf_cnt_next = '0;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        pix_valid_next = (state_next == ST_RUN) && (buf_cnt_next >= 6'd3);
    end

    // All outputs are registered from next-state values. They therefore
    // always describe the current buffer head, and they stay stable while a
    // pixel is stalled.
    always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
        if (!ddr3_emif_rst_n) begin
            state_reg       <= ST_IDLE;
            pix_num_reg     <= '0;
            pix_cnt_reg     <= '0;
            fifo_wr_ptr_reg <= '0;
            fifo_rd_ptr_reg <= '0;
            fifo_cnt_reg    <= '0;
            buf_reg         <= '0;
            buf_cnt_reg     <= '0;
            pix_valid_reg   <= 1'b0;
            pix_data_reg    <= '0;
            pix_sof_reg     <= 1'b0;
            pix_eof_reg     <= 1'b0;
            done_reg        <= 1'b0;
            read_req_reg    <= 1'b0;
            ovf_reg         <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pix_num_reg  <= pix_num_next;
            pix_cnt_reg  <= pix_cnt_next;
            fifo_cnt_reg <= fifo_cnt_next;
            buf_reg      <= buf_next;
            buf_cnt_reg  <= buf_cnt_next;
            if (fifo_wr) begin
                fifo_wr_ptr_reg <= fifo_wr_ptr_reg + AW'(1);
            end
            if (fifo_pop) begin
                fifo_rd_ptr_reg <= fifo_rd_ptr_reg + AW'(1);
            end
            pix_valid_reg <= pix_valid_next;
            pix_data_reg  <= pix_valid_next ? buf_next[23:0] : 24'd0;
            pix_sof_reg   <= pix_valid_next && (pix_cnt_next == '0);
            pix_eof_reg   <= pix_valid_next && (pix_cnt_next == pix_num_next - 32'd1);
            done_reg      <= (state_next == ST_FLUSH);
            // Keep SKID slots free so words already in flight always fit.
            read_req_reg  <= (state_next == ST_RUN) &&
                             ((32'(fifo_cnt_next) + 32'(SKID)) < 32'(FIFO_DEPTH));
            ovf_reg       <= ovf_reg | (read_data_valid_in && fifo_full);
        end
    end

`ifdef PIX_ERR_CHECK_EN
    logic [6:0] starve_cnt_reg;
    logic       pix_err_reg;
    logic       starving;

    assign starving = (state_reg == ST_RUN) && fifo_empty && (buf_cnt_reg < 6'd3);

    always_ff @(posedge ddr3_emif_clk or negedge ddr3_emif_rst_n) begin
        if (!ddr3_emif_rst_n) begin
            starve_cnt_reg <= '0;
            pix_err_reg    <= 1'b0;
        end else begin
            if (starving) begin
                // A value of 64 here means this is the 65th consecutive
                // starving cycle. The counter saturates at 127.
                if (starve_cnt_reg >= 7'd64) begin
                    pix_err_reg <= 1'b1;
                end
                if (starve_cnt_reg != 7'd127) begin
                    starve_cnt_reg <= starve_cnt_reg + 7'd1;
                end
            end else begin
                starve_cnt_reg <= '0;
            end
            if ((state_reg == ST_IDLE) && read_data_valid_in) begin
                pix_err_reg <= 1'b1;
            end
        end
    end

    assign pix_err_out = pix_err_reg;
`else
    assign pix_err_out = 1'b0;
`endif

    assign frame_done_out    = done_reg;
    assign read_req_out      = read_req_reg;
    assign pix_data_out      = pix_data_reg;
    assign pix_valid_out     = pix_valid_reg;
    assign pix_sof_out       = pix_sof_reg;
    assign pix_eof_out       = pix_eof_reg;
    assign fifo_overflow_out = ovf_reg;

endmodule

// File: tb/tb_ddr3_pix_gearbox.sv
// ---------------------------------------------------------------------------
// tb_ddr3_pix_gearbox
//
// Random-stimulus bench for ddr3_pix_gearbox. The reference model is a
// queue of FIFO words plus a queue of buffered bytes, with a frame state and
// a pixel counter. Every cycle, all DUT outputs are compared with the values
// the model predicts from that state.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddr3_pix_gearbox;

    localparam int DEPTH  = 8;
    localparam int SKID_W = 4;
    localparam int MAXCYC = 3000;

    logic          ddr3_emif_clk;
    logic          ddr3_emif_rst_n;
    logic          frame_start_in;
    logic [31:0]   frame_pix_num_in;
    logic          frame_done_out;
    logic          read_req_out;
    logic          data_ready_in;
    logic [287:0]  read_data_in;
    logic          read_data_valid_in;
    logic [23:0]   pix_data_out;
    logic          pix_valid_out;
    logic          pix_ready_in;
    logic          pix_sof_out;
    logic          pix_eof_out;
    logic          fifo_overflow_out;
    logic          pix_err_out;

    ddr3_pix_gearbox #(.FIFO_DEPTH(DEPTH), .SKID(SKID_W)) dut (
        .ddr3_emif_clk      (ddr3_emif_clk),
        .ddr3_emif_rst_n    (ddr3_emif_rst_n),
        .frame_start_in     (frame_start_in),
        .frame_pix_num_in   (frame_pix_num_in),
        .frame_done_out     (frame_done_out),
        .read_req_out       (read_req_out),
        .data_ready_in      (data_ready_in),
        .read_data_in       (read_data_in),
        .read_data_valid_in (read_data_valid_in),
        .pix_data_out       (pix_data_out),
        .pix_valid_out      (pix_valid_out),
        .pix_ready_in       (pix_ready_in),
        .pix_sof_out        (pix_sof_out),
        .pix_eof_out        (pix_eof_out),
        .fifo_overflow_out  (fifo_overflow_out),
        .pix_err_out        (pix_err_out)
    );

    initial ddr3_emif_clk = 1'b0;
    always #5 ddr3_emif_clk = ~ddr3_emif_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = idle, 1 = running, 2 = flush
    int            m_state;
    logic [255:0]  m_fifo[$];
    logic [7:0]    m_bytes[$];
    int unsigned   m_cnt, m_num;
    bit            m_ovf, m_err;
    int            m_starve;
    logic [7:0]    seq_byte = 8'd0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_fifo.delete();
        m_bytes.delete();
        m_cnt = 0; m_num = 0; m_ovf = 0; m_err = 0; m_starve = 0;
    endtask

    function automatic logic [255:0] next_word(input bit rnd);
        logic [255:0] w;
        for (int k = 0; k < 32; k++) begin
            if (rnd) begin
                w[8*k +: 8] = 8'($urandom);
            end else begin
                w[8*k +: 8] = seq_byte;
                seq_byte    = seq_byte + 8'd1;
            end
        end
        return w;
    endfunction

    // Advance the model by one clock, using the inputs currently being driven.
    task automatic model_step();
        bit          mv;
        bit          xfer;
        int          old_fifo;
        int          old_bytes;
        int unsigned old_cnt;
        logic [255:0] w;
        mv        = (m_state == 1) && (m_bytes.size() >= 3);
        xfer      = mv && pix_ready_in;
        old_fifo  = m_fifo.size();
        old_bytes = m_bytes.size();
        old_cnt   = m_cnt;
`ifdef PIX_ERR_CHECK_EN
        if ((m_state == 1) && (old_fifo == 0) && (old_bytes < 3)) begin
            if (m_starve >= 64) m_err = 1;
            m_starve++;
        end else begin
            m_starve = 0;
        end
        if ((m_state == 0) && read_data_valid_in) m_err = 1;
`endif
        if (xfer) begin
            repeat (3) void'(m_bytes.pop_front());
            m_cnt++;
        end
        if ((m_state == 1) && (m_bytes.size() < 3) && (old_fifo > 0)) begin
            w = m_fifo.pop_front();
            for (int k = 0; k < 32; k++) m_bytes.push_back(w[8*k +: 8]);
        end
        if (read_data_valid_in) begin
            if (old_fifo < DEPTH) m_fifo.push_back(read_data_in[255:0]);
            else m_ovf = 1;
        end
        case (m_state)
            0: if (frame_start_in) begin
                   m_num   = frame_pix_num_in;
                   m_cnt   = 0;
                   m_state = (frame_pix_num_in == 0) ? 2 : 1;
               end
            1: if (xfer && (old_cnt == m_num - 1)) m_state = 2;
            default: begin
                m_bytes.delete();
                m_state = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        bit mv;
        bit rr;
        mv = (m_state == 1) && (m_bytes.size() >= 3);
        rr = (m_state == 1) && ((DEPTH - m_fifo.size()) > SKID_W);
        check_val("pix_valid", 64'(pix_valid_out), 64'(mv));
        if (mv) begin
            check_val("pix_data", 64'(pix_data_out), 64'({m_bytes[2], m_bytes[1], m_bytes[0]}));
            check_val("pix_sof", 64'(pix_sof_out), 64'(m_cnt == 0));
            check_val("pix_eof", 64'(pix_eof_out), 64'(m_cnt == m_num - 1));
        end
        check_val("read_req", 64'(read_req_out), 64'(rr));
        check_val("frame_done", 64'(frame_done_out), 64'(m_state == 2));
        check_val("fifo_ovf", 64'(fifo_overflow_out), 64'(m_ovf));
        check_val("pix_err", 64'(pix_err_out), 64'(m_err));
    endtask

    task automatic cycle();
        model_step();
        @(posedge ddr3_emif_clk);
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, 64'(pix_valid_out), 64'd0);
        check_val({tag, "_data"},  64'(pix_data_out),  64'd0);
        check_val({tag, "_sof"},   64'(pix_sof_out),   64'd0);
        check_val({tag, "_eof"},   64'(pix_eof_out),   64'd0);
        check_val({tag, "_rreq"},  64'(read_req_out),  64'd0);
        check_val({tag, "_done"},  64'(frame_done_out), 64'd0);
        check_val({tag, "_ovf"},   64'(fifo_overflow_out), 64'd0);
        check_val({tag, "_err"},   64'(pix_err_out),   64'd0);
    endtask

    // rdy_mode: 0 random, 1 toggle, 2 always ready.
    // stop_at >= 0 leaves the frame once that many pixels have been accepted.
    task automatic run_frame(input int num, input int rdy_mode, input bit rnd,
                             input int push_delay, input int stop_at);
        int n;
        int pix_seen;
        int done_seen;
        bit stopped;
        frame_start_in     = 1'b1;
        frame_pix_num_in   = 32'(num);
        read_data_valid_in = 1'b0;
        pix_ready_in       = 1'b0;
        cycle();
        frame_start_in = 1'b0;
        done_seen = int'(frame_done_out);
        pix_seen  = 0;
        n         = 0;
        stopped   = 0;
        while ((m_state != 0) && (n < MAXCYC)) begin
            if ((stop_at >= 0) && (m_cnt == stop_at)) begin
                stopped = 1;
                break;
            end
            case (rdy_mode)
                0:       pix_ready_in = 1'($urandom_range(0, 1));
                1:       pix_ready_in = (n % 2 == 0);
                default: pix_ready_in = 1'b1;
            endcase
            read_data_valid_in = (n >= push_delay) && read_req_out && ($urandom_range(0, 3) != 0);
            if (read_data_valid_in) read_data_in = {$urandom, next_word(rnd)};
            else                    read_data_in = {9{$urandom}};
            frame_start_in   = ($urandom_range(0, 15) == 0);
            frame_pix_num_in = $urandom_range(0, 50);
            if (pix_valid_out && pix_ready_in) pix_seen++;
            if ((push_delay > 0) && (n == push_delay)) begin
`ifdef PIX_ERR_CHECK_EN
                check_val("starve_err", 64'(pix_err_out), 64'd1);
`else
                check_val("starve_err", 64'(pix_err_out), 64'd0);
`endif
            end
            cycle();
            n++;
            if (frame_done_out) done_seen++;
        end
        frame_start_in     = 1'b0;
        read_data_valid_in = 1'b0;
        pix_ready_in       = 1'b0;
        if (!stopped) begin
            check_val("frame_timeout", 64'(n < MAXCYC), 64'd1);
            check_val("frame_pixels", 64'(pix_seen), 64'(num));
            check_val("frame_done_cnt", 64'(done_seen), 64'd1);
        end
        $display("[TB] frame num=%0d pixels=%0d cycles=%0d stopped=%0d", num, pix_seen, n, stopped);
    endtask

    initial begin
        ddr3_emif_rst_n    = 1'b0;
        frame_start_in     = 1'b0;
        frame_pix_num_in   = '0;
        data_ready_in      = 1'b1;
        read_data_in       = '0;
        read_data_valid_in = 1'b0;
        pix_ready_in       = 1'b0;
        model_reset();
        repeat (3) @(posedge ddr3_emif_clk);
        #1;
        check_all_zero("reset");
        ddr3_emif_rst_n = 1'b1;

        // Sequential byte patterns (first pixel 0x020100), then edge cases.
        run_frame(32, 2, 0, 0, -1);
        run_frame(11, 2, 0, 0, -1);
        run_frame(64, 1, 0, 0, -1);
        run_frame(0,  2, 0, 0, -1);
        run_frame(1,  0, 1, 0, -1);
        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(1, 120), $urandom_range(0, 2), 1, 0, -1);
        end

        // Overflow: push DEPTH+1 words while idle, ignoring read_req.
        pix_ready_in = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            read_data_valid_in = 1'b1;
            read_data_in       = {$urandom, next_word(1)};
            cycle();
        end
        read_data_valid_in = 1'b0;
        repeat (5) cycle();
        check_val("ovf_sticky", 64'(fifo_overflow_out), 64'd1);
        $display("[TB] overflow push of %0d words", DEPTH + 1);
        run_frame(40, 0, 1, 0, -1);
        check_val("ovf_after_frame", 64'(fifo_overflow_out), 64'd1);

        // Reset in the middle of a frame, after 10 pixels have been accepted.
        run_frame(32, 2, 0, 0, 10);
        ddr3_emif_rst_n = 1'b0;
        #2;
        check_all_zero("midrst");
        model_reset();
        @(posedge ddr3_emif_clk);
        @(posedge ddr3_emif_clk);
        #1;
        check_all_zero("midrst_hold");
        ddr3_emif_rst_n = 1'b1;
        $display("[TB] mid-frame reset applied");

        // FIFO is empty after reset: start a frame that starves for 70 cycles.
        run_frame(20, 2, 0, 70, -1);
        run_frame(32, 0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
